// File: rtl/nfu_3_pwl.sv
// nfu_3_pwl -- Tn-channel piecewise-linear function unit.
// Each channel computes y = ((x * a) >>> Q) + b, where {a,b} comes from a
// shared 2^SEG_BITS-entry table indexed by the top bits of x (offset binary,
// so the most-negative x selects segment 0). Three-stage pipeline, no stall.
// Table writes are only accepted while the pipeline is empty.
// Optional build macro: NFU3_PWL_SATURATE_EN -- clamp S2 and S3 results to
// the signed BIT_WIDTH range instead of wrapping.
module nfu_3_pwl #(
   parameter int BIT_WIDTH = 16,
   parameter int Q         = 10,
   parameter int Tn        = 16,
   parameter int SEG_BITS  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic                    i_bypass,
   input  logic [Tn*BIT_WIDTH-1:0] i_x,
   input  logic                    i_coef_we,
   input  logic [SEG_BITS-1:0]     i_coef_addr,
   input  logic [2*BIT_WIDTH-1:0]  i_coef,
   output logic                    o_coef_ready,
   output logic                    o_valid,
   output logic [Tn*BIT_WIDTH-1:0] o_y
);

   localparam int BW   = BIT_WIDTH;
   localparam int PW   = 2 * BIT_WIDTH;
   localparam int NSEG = 1 << SEG_BITS;

   // Reduce a wide signed intermediate to BW bits (clamp or two's-complement wrap).
   function automatic logic signed [BW-1:0] fit(input logic signed [PW-1:0] v);
`ifdef NFU3_PWL_SATURATE_EN
      if (v[PW-1:BW-1] != {(PW-BW+1){v[PW-1]}})
         fit = v[PW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      else
         fit = v[BW-1:0];
`else
      fit = v[BW-1:0];
`endif
   endfunction

   // Coefficient table
   logic signed [BW-1:0] tab_a [NSEG];
   logic signed [BW-1:0] tab_b [NSEG];

   // Stage registers
   logic signed [BW-1:0] x_p1 [Tn];
   logic signed [BW-1:0] a_p1 [Tn];
   logic signed [BW-1:0] b_p1 [Tn];
   logic                 byp_p1;
   logic                 vld_p1;

   logic signed [BW-1:0] p_p2 [Tn];
   logic signed [BW-1:0] b_p2 [Tn];
   logic                 vld_p2;

   logic signed [BW-1:0] y_p3 [Tn];
   logic                 vld_p3;

   // Combinational per-channel signals
   logic signed [BW-1:0]   x_in   [Tn];
   logic [SEG_BITS-1:0]    seg    [Tn];
   logic signed [BW-1:0]   p_nxt  [Tn];
   logic signed [BW-1:0]   b_nxt  [Tn];
   logic signed [BW-1:0]   y_nxt  [Tn];

   logic coef_wr;

   assign o_coef_ready = ~(vld_p1 | vld_p2 | vld_p3);
   assign coef_wr      = i_coef_we & o_coef_ready;
   assign o_valid      = vld_p3;

   // Unpack channels and form the segment index from the offset-binary top bits.
   always_comb begin
      for (int i = 0; i < Tn; i++) begin
         x_in[i] = i_x[i*BW +: BW];
         seg[i]  = {~x_in[i][BW-1], x_in[i][BW-2 -: (SEG_BITS-1)]};
      end
   end

   // Table write; S1 reads the same flops on this edge, so a simultaneous sample sees the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSEG; s++) begin
            tab_a[s] <= '0;
            tab_b[s] <= '0;
         end
      end else if (coef_wr) begin
         tab_a[i_coef_addr] <= i_coef[PW-1:BW];
         tab_b[i_coef_addr] <= i_coef[BW-1:0];
      end
   end

   // ---- S1: capture x, looked-up {a,b}, bypass ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         byp_p1 <= 1'b0;
         for (int i = 0; i < Tn; i++) begin
            x_p1[i] <= '0;
            a_p1[i] <= '0;
            b_p1[i] <= '0;
         end
      end else begin
         vld_p1 <= i_valid;
         if (i_valid) begin
            byp_p1 <= i_bypass;
            for (int i = 0; i < Tn; i++) begin
               x_p1[i] <= x_in[i];
               a_p1[i] <= tab_a[seg[i]];
               b_p1[i] <= tab_b[seg[i]];
            end
         end
      end
   end

   // Full-width product, floor shift by Q; bypass forwards x with a zero offset.
   always_comb begin
      for (int i = 0; i < Tn; i++) begin
         logic signed [PW-1:0] prod;
         prod = PW'(x_p1[i]) * PW'(a_p1[i]);
         if (byp_p1) begin
            p_nxt[i] = x_p1[i];
            b_nxt[i] = '0;
         end else begin
            p_nxt[i] = fit(prod >>> Q);
            b_nxt[i] = b_p1[i];
         end
      end
   end

   // ---- S2: register scaled product and offset ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         for (int i = 0; i < Tn; i++) begin
            p_p2[i] <= '0;
            b_p2[i] <= '0;
         end
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            for (int i = 0; i < Tn; i++) begin
               p_p2[i] <= p_nxt[i];
               b_p2[i] <= b_nxt[i];
            end
         end
      end
   end

   // Offset add in full width, then reduce.
   always_comb begin
      for (int i = 0; i < Tn; i++) begin
         y_nxt[i] = fit(PW'(p_p2[i]) + PW'(b_p2[i]));
      end
   end

   // ---- S3: output register, holds when no valid vector arrives ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p3 <= 1'b0;
         for (int i = 0; i < Tn; i++) y_p3[i] <= '0;
      end else begin
         vld_p3 <= vld_p2;
         if (vld_p2) begin
            for (int i = 0; i < Tn; i++) y_p3[i] <= y_nxt[i];
         end
      end
   end

   for (genvar g = 0; g < Tn; g++) begin : g_pack
      assign o_y[g*BW +: BW] = y_p3[g];
   end

endmodule

// File: tb/tb_nfu_3_pwl.sv
// tb_nfu_3_pwl -- directed-vector bench for nfu_3_pwl with default parameters.
module tb_nfu_3_pwl;

   localparam int BW = 16;
   localparam int TN = 16;
   localparam int SB = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_valid;
   logic              i_bypass;
   logic [TN*BW-1:0]  i_x;
   logic              i_coef_we;
   logic [SB-1:0]     i_coef_addr;
   logic [2*BW-1:0]   i_coef;
   logic              o_coef_ready;
   logic              o_valid;
   logic [TN*BW-1:0]  o_y;

   int checks = 0;
   int errors = 0;

   nfu_3_pwl #(.BIT_WIDTH(BW), .Q(10), .Tn(TN), .SEG_BITS(SB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .i_bypass     (i_bypass),
      .i_x          (i_x),
      .i_coef_we    (i_coef_we),
      .i_coef_addr  (i_coef_addr),
      .i_coef       (i_coef),
      .o_coef_ready (o_coef_ready),
      .o_valid      (o_valid),
      .o_y          (o_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] ch(input int i);
      return o_y[i*BW +: BW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_valid   = 1'b0;
      i_bypass  = 1'b0;
      i_coef_we = 1'b0;
   endtask

   task automatic wr(input logic [SB-1:0] seg, input logic [BW-1:0] a, input logic [BW-1:0] b);
      i_coef_we   = 1'b1;
      i_coef_addr = seg;
      i_coef      = {a, b};
      step();
      i_coef_we   = 1'b0;
   endtask

   // One isolated vector: all channels = x; checks latency, value, hold.
   task automatic run(input string tag, input logic [BW-1:0] x, input logic byp,
                      input logic [BW-1:0] exp);
      i_valid  = 1'b1;
      i_bypass = byp;
      i_x      = {TN{x}};
      step();
      idle();
      chk({tag, "_rdy_busy"}, o_coef_ready, 0);
      step();
      chk({tag, "_vld_early"}, o_valid, 0);
      step();
      chk({tag, "_vld"}, o_valid, 1);
      chk({tag, "_y0"}, ch(0), exp);
      chk({tag, "_ylast"}, ch(TN-1), exp);
      step();
      chk({tag, "_vld_off"}, o_valid, 0);
      chk({tag, "_hold"}, ch(0), exp);
   endtask

   initial begin
      rst_n       = 1'b0;
      i_x         = '0;
      i_coef_addr = '0;
      i_coef      = '0;
      idle();
      step();
      step();
      chk("rst_vld", o_valid, 0);
      chk("rst_y", o_y[31:0], 0);
      chk("rst_rdy", o_coef_ready, 1);
      rst_n = 1'b1;
      step();
      chk("rel_rdy", o_coef_ready, 1);

      // Unloaded table gives zero.
      run("empty", 16'h0400, 1'b0, 16'h0000);

      // 0.25 * 1.0 + 0.5 = 0.75
      wr(4'd8, 16'h0100, 16'h0200);
      run("basic", 16'h0400, 1'b0, 16'h0300);

      // Bypass: ch3 distinct value, everything else different.
      i_valid  = 1'b1;
      i_bypass = 1'b1;
      i_x      = {TN{16'h1234}};
      i_x[3*BW +: BW] = 16'h8001;
      step();
      idle();
      step();
      step();
      chk("byp_vld", o_valid, 1);
      chk("byp_ch3", ch(3), 16'h8001);
      chk("byp_ch0", ch(0), 16'h1234);
      step();

      // Negative x, floor shift: -1/1024 * 0.25 floors to -1 LSB.
      wr(4'd7, 16'h0100, 16'h0000);
      run("floor_small", 16'hFFFF, 1'b0, 16'hFFFF);
      run("floor_neg", 16'hF000, 1'b0, 16'hFC00);

      // Most-negative x selects segment 0.
      wr(4'd0, 16'h0000, 16'h0123);
      run("seg0", 16'h8000, 1'b0, 16'h0123);

      // Back-to-back writes to one address: last wins.
      wr(4'd2, 16'h0000, 16'h0011);
      wr(4'd2, 16'h0000, 16'h0022);
      run("wr_last", 16'hA000, 1'b0, 16'h0022);

      // Eight-vector stream, with a write attempt while busy that must be ignored.
      for (int c = 0; c < 12; c++) begin
         i_valid  = (c < 8);
         i_bypass = 1'b0;
         i_x      = {TN{16'(c * 16'h0100)}};
         i_coef_we   = (c == 3);
         i_coef_addr = 4'd8;
         i_coef      = {16'h7000, 16'h7000};
         step();
         chk($sformatf("strm_vld%0d", c), o_valid, (c >= 2 && c <= 9));
         chk($sformatf("strm_rdy%0d", c), o_coef_ready, (c >= 10));
         if (c >= 2 && c <= 9)
            chk($sformatf("strm_y%0d", c), ch(5), 16'(16'h0200 + (c - 2) * 16'h0040));
      end
      idle();
      run("ign_wr", 16'h0400, 1'b0, 16'h0300);

      // Write and sample on the same edge: sample sees old entry.
      i_valid     = 1'b1;
      i_x         = {TN{16'h0400}};
      i_coef_we   = 1'b1;
      i_coef_addr = 4'd8;
      i_coef      = {16'h0000, 16'h0100};
      step();
      i_coef_we = 1'b0;
      step();
      idle();
      step();
      chk("rbw_vld_a", o_valid, 1);
      chk("rbw_old", ch(0), 16'h0300);
      step();
      chk("rbw_vld_b", o_valid, 1);
      chk("rbw_new", ch(0), 16'h0100);
      step();

      // Overflow: product 0x3FFF0001>>>10 = 0xFFFC0; wrap -> 0xFFC0, +0x7FFF -> 0x7FBF.
      wr(4'd15, 16'h7FFF, 16'h7FFF);
`ifdef NFU3_PWL_SATURATE_EN
      run("ovf", 16'h7FFF, 1'b0, 16'h7FFF);
`else
      run("ovf", 16'h7FFF, 1'b0, 16'h7FBF);
`endif

      // Reset one cycle after a vector enters.
      wr(4'd8, 16'h0100, 16'h0200);
      i_valid = 1'b1;
      i_x     = {TN{16'h0400}};
      step();
      idle();
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", o_valid, 0);
      chk("mid_rst_y", ch(0), 16'h0000);
      chk("mid_rst_rdy", o_coef_ready, 1);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("post_rst_vld%0d", c), o_valid, 0);
      end
      chk("post_rst_rdy", o_coef_ready, 1);
      run("post_rst_zero", 16'h0400, 1'b0, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nfu_3_pwl.md
NFU_3_PWL -- requirements
Module: nfu_3_pwl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning the signed fixed-point word width.
REQ-002 SHALL have parameter Q, default 10, meaning the number of fractional bits.
REQ-003 SHALL have parameter Tn, default 16, meaning the number of parallel channels.
REQ-004 SHALL have parameter SEG_BITS, default 4, giving 2^SEG_BITS segments (2..6 supported).
REQ-005 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-006 Ports SHALL be as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input vector valid.
- i_bypass  in  1  identity mode for this vector.
- i_x  in  Tn*BIT_WIDTH  channel i at bits [(i+1)*BIT_WIDTH-1 : i*BIT_WIDTH].
- i_coef_we  in  1  coefficient write request.
- i_coef_addr  in  SEG_BITS  segment index to write.
- i_coef  in  2*BIT_WIDTH  {a (upper), b (lower)}, signed Q-format.
- o_coef_ready  out  1  coefficient write is accepted this cycle.
- o_valid  out  1  output vector valid.
- o_y  out  Tn*BIT_WIDTH  result, same packing as i_x.

Function
REQ-007 All channels SHALL share a single 2^SEG_BITS-entry {a,b} table held in flops.
REQ-008 Segment index per channel SHALL be {~x[BIT_WIDTH-1], x[BIT_WIDTH-2 : BIT_WIDTH-SEG_BITS]}, so the most-negative x maps to segment 0.
REQ-009 Pipeline S1 SHALL register x, the looked-up a and b, bypass, and valid on every edge when i_valid=1.
REQ-010 Pipeline S2 SHALL register p = (x*a) as a full 2*BIT_WIDTH signed product, arithmetically shifted right by Q (floor).
REQ-011 Pipeline S3 SHALL register y = p + b into o_y, together with o_valid.
REQ-012 Latency SHALL be exactly 3 cycles from i_valid to o_valid, with a throughput of one vector per cycle.
REQ-013 The pipeline SHALL have no stall and SHALL never drop or reorder vectors.
REQ-014 When i_valid=0, the stage valid bits SHALL propagate as 0 and o_y SHALL hold its previous value.
REQ-015 In bypass mode, o_y SHALL equal x unchanged, with the same 3-cycle latency, and the table SHALL not be consulted.
REQ-016 o_coef_ready SHALL be 1 iff no S1/S2/S3 valid bit is set.
REQ-017 A write SHALL commit at the edge where i_coef_we=1 and o_coef_ready=1; a write with o_coef_ready=0 SHALL be ignored.
REQ-018 Simultaneous accepted write and i_valid: the sample SHALL use the pre-write table entry (read-before-write), and the write SHALL still commit.
REQ-019 Writing the same address on consecutive cycles SHALL keep the last value.

Reset
REQ-020 rst_n low SHALL asynchronously clear all stage valid bits, o_valid, o_y, and every table entry to 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight vectors, and no o_valid SHALL appear for them.
REQ-022 After reset release, o_coef_ready SHALL be 1, and an unloaded table SHALL yield o_y = 0 for non-bypass vectors.

Configuration
REQ-023 With macro NFU3_PWL_SATURATE_EN defined, S2 shift-result and S3 sum SHALL each clamp to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
REQ-024 Without NFU3_PWL_SATURATE_EN, S2 and S3 SHALL keep the low BIT_WIDTH bits (two's-complement wrap).

Verification
REQ-025 Load seg 8 with a=0x0100 (0.25), b=0x0200 (0.5), Q=10; send x=0x0400 (1.0) -> o_y=0x0300 (0.75) exactly 3 cycles later.
REQ-026 Send back-to-back vectors for 8 cycles -> 8 consecutive o_valid pulses in order; o_coef_ready=0 from cycle 1 until 3 cycles after the last vector.
REQ-027 Assert i_coef_we with i_valid on the same edge, writing seg 8 a=0 b=0x0100 -> that x=0x0400 still yields 0x0300, and the next vector yields 0x0100.
REQ-028 Load seg 15 a=0x7FFF b=0x7FFF; send x=0x7FFF -> 0x7FFF with NFU3_PWL_SATURATE_EN, wrapped low bits without it.
REQ-029 Send i_bypass=1 with x=0x8001 on channel 3 -> o_y channel 3 = 0x8001 after 3 cycles, regardless of table contents.
REQ-030 Drop rst_n one cycle after i_valid -> o_valid stays 0, o_y=0, the table is zeroed, and o_coef_ready=1 after release.
